// File: rtl/lcd_data_path.sv
// LCD data-bus stage for the sejf display path: init table / 2-line char buffer mux; define SEJF_PIN_MASK_EN for PIN masking.
// DB_out has 1-cycle latency from selects/char_ptr/buffer; no backpressure (controller paces transfers via E_out).
`timescale 1ns/1ps
module lcd_data_path #(
  parameter int          COLS       = 16,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  parameter int          PIN_COL    = 0
) (
  input  logic                        clk_1ms,
  input  logic                        reset,
  input  logic                        DB_sel,
  input  logic                        data_sel,
  input  logic [1:0]                  init_sel,
  input  logic [1:0]                  mux_sel,
  input  logic                        E_out,
  input  logic                        wr_en,
  input  logic [$clog2(2*COLS)-1:0]   wr_addr,
  input  logic [7:0]                  wr_data,
`ifdef SEJF_PIN_MASK_EN
  input  logic                        pin_mask,
`endif
  output logic [7:0]                  DB_out,
  output logic [$clog2(2*COLS)-1:0]   char_ptr,
  output logic                        refresh_req,
  output logic                        frame_done
);

  localparam int DEPTH = 2 * COLS;
  localparam int AW    = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;

  localparam ptr_t LINE2     = ptr_t'(COLS);
  localparam ptr_t LAST1     = ptr_t'(COLS - 1);
  localparam ptr_t LAST2     = ptr_t'(DEPTH - 1);
  localparam ptr_t PIN_START = ptr_t'(COLS + PIN_COL);

  logic [7:0] char_buf [DEPTH];
  logic       e_q;
  logic       e_fall;
  logic       addr_ok;
  logic       wr_ok;
  logic       pin_en;
  logic [7:0] cur_char;
  logic [7:0] shown;
  logic [7:0] db_nxt;
  ptr_t       ptr_nxt;
  logic       done_nxt;

  // Non-power-of-two depths need an explicit range check on the write address.
  generate
    if (DEPTH == (2 ** AW)) begin : g_full_range
      assign addr_ok = 1'b1;
    end else begin : g_part_range
      assign addr_ok = (wr_addr < ptr_t'(DEPTH));
    end
  endgenerate

`ifdef SEJF_PIN_MASK_EN
  assign pin_en = pin_mask;
`else
  assign pin_en = 1'b0;
`endif

  assign wr_ok  = wr_en && addr_ok;
  assign e_fall = e_q && !E_out;

  always_comb begin
    cur_char = char_buf[char_ptr];
    shown    = cur_char;
    // Masking only changes what is driven; the stored PIN digits stay intact.
    if (pin_en && (char_ptr >= PIN_START) && (cur_char >= 8'h30) && (cur_char <= 8'h39))
      shown = 8'h2A;
    db_nxt = 8'h00;
    if (DB_sel) begin
      if (!data_sel) begin
        case (init_sel)
          2'd0:    db_nxt = 8'h38;
          2'd1:    db_nxt = 8'h0C;
          2'd2:    db_nxt = 8'h06;
          default: db_nxt = 8'h01;
        endcase
      end else begin
        case (mux_sel)
          2'd0:    db_nxt = 8'h80;
          2'd1:    db_nxt = shown;
          2'd2:    db_nxt = 8'hC0;
          default: db_nxt = 8'h02;
        endcase
      end
    end
  end

  always_comb begin
    ptr_nxt  = char_ptr;
    done_nxt = 1'b0;
    if (e_fall && data_sel) begin
      case (mux_sel)
        2'd0: ptr_nxt = '0;
        2'd2: ptr_nxt = LINE2;
        2'd1: begin
          if (char_ptr == LAST2) begin
            ptr_nxt  = '0;
            done_nxt = 1'b1;
          end else if (char_ptr != LAST1) begin
            ptr_nxt = char_ptr + ptr_t'(1);
          end
        end
        default: ptr_nxt = char_ptr;
      endcase
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) char_buf[i] <= BLANK_CHAR;
      DB_out      <= 8'h00;
      char_ptr    <= '0;
      refresh_req <= 1'b1;
      frame_done  <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      e_q        <= E_out;
      DB_out     <= db_nxt;
      char_ptr   <= ptr_nxt;
      frame_done <= done_nxt;
      if (wr_ok) char_buf[wr_addr] <= wr_data;
      // A write landing while frame_done is high keeps the request pending.
      if (wr_ok)
        refresh_req <= 1'b1;
      else if (frame_done)
        refresh_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_data_path.sv
// Scoreboard bench for lcd_data_path: driver queues expected DB bytes per E pulse, monitor compares while E_out is high.
`timescale 1ns/1ps
module tb_lcd_data_path;
  logic       clk_1ms = 1'b0;
  logic       reset = 1'b0;
  logic       DB_sel = 1'b0;
  logic       data_sel = 1'b0;
  logic [1:0] init_sel = 2'd0;
  logic [1:0] mux_sel = 2'd0;
  logic       E_out = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'h00;
`ifdef SEJF_PIN_MASK_EN
  logic       pin_mask = 1'b0;
`endif
  logic [7:0] DB_out;
  logic [4:0] char_ptr;
  logic       refresh_req;
  logic       frame_done;

  int total = 0;
  int bad = 0;
  int fd_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [32];

  always #5 clk_1ms = ~clk_1ms;

  lcd_data_path dut (
    .clk_1ms(clk_1ms), .reset(reset), .DB_sel(DB_sel), .data_sel(data_sel),
    .init_sel(init_sel), .mux_sel(mux_sel), .E_out(E_out), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SEJF_PIN_MASK_EN
    .pin_mask(pin_mask),
`endif
    .DB_out(DB_out), .char_ptr(char_ptr), .refresh_req(refresh_req), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_1ms) begin
    if (frame_done) fd_count++;
    if (E_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL db_unexpected: got %0h expected no transfer", DB_out);
      end else begin
        chk("db_out", DB_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_1ms);
    #1;
  endtask

  // Selects first, then a one-cycle E pulse, then one idle cycle so the falling edge sees the same selects.
  task automatic xfer(input logic dbs, input logic ds, input logic [1:0] sel, input logic [7:0] exp);
    DB_sel = dbs; data_sel = ds; init_sel = sel; mux_sel = sel; E_out = 1'b0;
    step();
    E_out = 1'b1;
    exp_q.push_back(exp);
    step();
    E_out = 1'b0;
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic frame(input logic collide);
    xfer(1, 1, 2'd0, 8'h80);
    for (int i = 0; i < 16; i++) xfer(1, 1, 2'd1, model[i]);
    xfer(1, 1, 2'd2, 8'hC0);
    for (int i = 16; i < 32; i++) xfer(1, 1, 2'd1, model[i]);
    chk("frame_done_high", frame_done, 1);
    if (collide) begin
      wr(5'd5, 8'h58);
      chk("collide_refresh_req", refresh_req, 1);
      step();
      chk("collide_refresh_req_hold", refresh_req, 1);
    end else begin
      step();
      chk("frame_refresh_req_clr", refresh_req, 0);
    end
    chk("frame_done_low", frame_done, 0);
    chk("frame_ptr_wrap", char_ptr, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_db", DB_out, 8'h00);
    chk("rst_ptr", char_ptr, 0);
    chk("rst_refresh_req", refresh_req, 1);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b1;

    xfer(1, 0, 2'd0, 8'h38);
    xfer(1, 0, 2'd1, 8'h0C);
    xfer(1, 0, 2'd2, 8'h06);
    xfer(1, 0, 2'd3, 8'h01);
    chk("init_ptr", char_ptr, 0);
    chk("init_refresh_req", refresh_req, 1);

    wr(5'd0, "S"); wr(5'd1, "E"); wr(5'd2, "J"); wr(5'd3, "F");
    wr(5'd16, "1"); wr(5'd17, "2"); wr(5'd18, "3"); wr(5'd19, "4");
    frame(1'b0);
    chk("frame1_count", fd_count, 1);

    xfer(1, 1, 2'd0, 8'h80);
    for (int i = 0; i < 16; i++) xfer(1, 1, 2'd1, model[i]);
    chk("hold_ptr_pre", char_ptr, 15);
    xfer(1, 1, 2'd1, model[15]);
    chk("hold_ptr", char_ptr, 15);
    chk("hold_no_done", fd_count, 1);

    frame(1'b1);
    chk("frame2_count", fd_count, 2);
    xfer(1, 1, 2'd0, 8'h80);
    for (int i = 0; i < 6; i++) xfer(1, 1, 2'd1, model[i]);

    xfer(0, 1, 2'd1, 8'h00);
    xfer(0, 0, 2'd0, 8'h00);

    xfer(1, 1, 2'd2, 8'hC0);
    for (int i = 16; i < 20; i++) xfer(1, 1, 2'd1, model[i]);
    chk("mid_ptr", char_ptr, 20);
    reset = 1'b0;
    repeat (2) step();
    chk("midrst_ptr", char_ptr, 0);
    chk("midrst_db", DB_out, 8'h00);
    chk("midrst_refresh_req", refresh_req, 1);
    chk("midrst_frame_done", frame_done, 0);
    reset = 1'b1;
    step();
    chk("midrst_no_done", fd_count, 2);
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    frame(1'b0);
    chk("frame3_count", fd_count, 3);

`ifdef SEJF_PIN_MASK_EN
    pin_mask = 1'b1;
    wr(5'd16, "1"); wr(5'd17, "2"); wr(5'd18, "A"); wr(5'd19, "4");
    xfer(1, 1, 2'd2, 8'hC0);
    xfer(1, 1, 2'd1, 8'h2A);
    xfer(1, 1, 2'd1, 8'h2A);
    xfer(1, 1, 2'd1, "A");
    xfer(1, 1, 2'd1, 8'h2A);
    pin_mask = 1'b0;
    xfer(1, 1, 2'd2, 8'hC0);
    xfer(1, 1, 2'd1, "1");
    xfer(1, 1, 2'd1, "2");
    xfer(1, 1, 2'd1, "A");
    xfer(1, 1, 2'd1, "4");
`endif

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
